dense_layer_engine: RTL and testbench
=====================================

Name: dense_layer_engine

Overview:
Parametrised, time-multiplexed fully-connected layer for the SNN/ANN inference path. Computes y[j] = act((b[j] + sum_i x[i]*w[j][i]) >>> FRAC_SHIFT) for N_OUT neurons over an N_IN-wide input, using one signed MAC. Operands come from external synchronous memories. Results stream out one neuron at a time under a valid/ready handshake, so layers chain without padding buses or counter-done reset tricks.

Parameters:
N_IN, 784, input vector length (>=2)
N_OUT, 10, neuron count (>=2)
IN_W, 32, signed width of x_data and w_data
B_W, 32, signed width of b_data
ACC_W, 80, accumulator width; must be >= 2*IN_W + clog2(N_IN) + 1
OUT_W, 40, signed output width after saturation
FRAC_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  pulse; begins a layer pass when idle
act_relu  in  1  1=ReLU, 0=identity; sampled at start
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse after the last output handshake
x_addr  out  clog2(N_IN)  input memory address
x_data  in  IN_W  input data, 1-cycle read latency
w_addr  out  clog2(N_IN*N_OUT)  weight address = j*N_IN + i
w_data  in  IN_W  weight data, 1-cycle read latency
b_addr  out  clog2(N_OUT)  bias address = j
b_data  in  B_W  bias data, 1-cycle read latency
y_valid  out  1  output valid
y_ready  in  1  downstream ready
y_idx  out  clog2(N_OUT)  neuron index of y_data
y_data  out  OUT_W  signed result

Behaviour:
- Reset (async, rstn=0): state IDLE. busy, done, y_valid = 0. y_idx, y_data, all addresses, accumulator and counters = 0. Reset mid-pass abandons the pass and produces no further outputs.
- States: IDLE, BIAS, MAC, DRAIN, OUT.
- IDLE: start=1 latches act_relu, sets j=0 and busy=1, and moves to BIAS. start is ignored in every other state.
- BIAS (1 cycle): b_addr=j. Next state MAC with i=0.
- MAC (N_IN cycles): x_addr=i, w_addr=j*N_IN+i, i increments each cycle.
  - First MAC cycle: acc <= sign-extended b_data.
  - Later MAC cycles: acc <= acc + x_data*w_data, the product of the previous cycle's addresses.
  - After i=N_IN-1, go to DRAIN.
- DRAIN (1 cycle): adds the last product.
- OUT: r = acc >>> FRAC_SHIFT.
  - If act_relu and r<0, then r=0.
  - Saturate r to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register the result to y_data; y_idx=j; y_valid=1.
- Output hold: y_valid, y_data, y_idx and all addresses stay stable until y_valid & y_ready.
- On handshake: y_valid drops the next cycle. If j=N_OUT-1, go to IDLE, pulse done for 1 cycle, drop busy in the same cycle. Otherwise j++ and go to BIAS.
- Latency: with y_ready tied high, y_valid for neuron j first asserts N_IN+3 cycles after the start cycle plus j*(N_IN+3). done asserts one cycle after the final handshake.
- Products are full 2*IN_W signed. The accumulator wraps modulo 2^ACC_W; no overflow occurs if the ACC_W rule holds.
- A start issued in the same cycle as done is ignored; start is accepted only once the block is in IDLE.
- Address outputs are registered and change only on state or counter updates.

Test Plan:
- N_IN=4, N_OUT=3, OUT_W=40, FRAC_SHIFT=0, act_relu=0, y_ready=1; x=[1,2,3,4], w0=[1,1,1,1], b0=5 -> y_idx=0, y_data=15, first y_valid 7 cycles after start, then y_idx 1 and 2 at +7 cycle spacing, done 1 cycle after the third handshake.
- w1=[-1,-1,-1,-1], b1=0: act_relu=0 -> y_data=-10; act_relu=1 -> y_data=0. Neuron 0 (15) is unchanged by ReLU.
- OUT_W=8, IN_W=8, x=[127]*4, w2=[127]*4, b2=0 -> 64516 saturates to 127. With w2=[-128]*4 -> -65024 saturates to -128.
- FRAC_SHIFT=2 with the first two vectors -> 15>>>2=3; -10>>>2=-3 (act_relu=0).
- y_ready held low 5 cycles while y_valid=1 -> y_valid, y_data, y_idx, x_addr, w_addr, b_addr unchanged; the pass resumes on y_ready=1 with correct subsequent results.
- Pulse rstn low during MAC of neuron 1 -> busy=0, y_valid=0, done=0 immediately. A second start pulse during busy is ignored (single done). A fresh start after reset yields 15, -10, then the third result.

Source files
------------

// File: rtl/dense_layer_engine.sv
// Time-multiplexed fully-connected layer: one signed MAC walks N_IN inputs per
// neuron and streams saturated, optionally rectified results under valid/ready.
module dense_layer_engine #(
    parameter int N_IN       = 784,
    parameter int N_OUT      = 10,
    parameter int IN_W       = 32,
    parameter int B_W        = 32,
    parameter int ACC_W      = 80,
    parameter int OUT_W      = 40,
    parameter int FRAC_SHIFT = 0,
    localparam int XA_W = $clog2(N_IN),
    localparam int WA_W = $clog2(N_IN * N_OUT),
    localparam int YA_W = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    act_relu,
    output logic                    busy,
    output logic                    done,
    output logic [XA_W-1:0]         x_addr,
    input  logic signed [IN_W-1:0]  x_data,
    output logic [WA_W-1:0]         w_addr,
    input  logic signed [IN_W-1:0]  w_data,
    output logic [YA_W-1:0]         b_addr,
    input  logic signed [B_W-1:0]   b_data,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [YA_W-1:0]         y_idx,
    output logic signed [OUT_W-1:0] y_data
);

    typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, OUT} state_t;

    localparam logic [XA_W-1:0] LAST_I = XA_W'(N_IN - 1);
    localparam logic [YA_W-1:0] LAST_J = YA_W'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t                  state, state_nx;
    logic                    relu_q;
    logic [WA_W-1:0]         w_base;
    logic signed [ACC_W-1:0] acc;
    logic signed [2*IN_W-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    accept;
    logic                    handshake;

    function automatic logic signed [ACC_W-1:0] scale_relu(input logic signed [ACC_W-1:0] v,
                                                            input logic relu);
        logic signed [ACC_W-1:0] r;
        r = v >>> FRAC_SHIFT;
        if (relu && r[ACC_W-1]) r = '0;
        return r;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction

    // A start coinciding with the done pulse must not retrigger the engine.
    assign accept    = (state == IDLE) && start && !done;
    assign handshake = y_valid && y_ready;

    assign prod     = x_data * w_data;
    assign prod_ext = {{(ACC_W-2*IN_W){prod[2*IN_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-B_W){b_data[B_W-1]}}, b_data};
    assign acc_sum  = acc + prod_ext;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = BIAS;
            BIAS:    state_nx = MAC;
            MAC:     if (x_addr == LAST_I) state_nx = DRAIN;
            DRAIN:   state_nx = OUT;
            OUT:     if (handshake) state_nx = (b_addr == LAST_J) ? IDLE : BIAS;
            default: state_nx = IDLE;
        endcase
    end

    // b_addr doubles as the neuron counter j; x_addr doubles as the input counter i.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            relu_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            x_addr  <= '0;
            w_addr  <= '0;
            b_addr  <= '0;
            w_base  <= '0;
            acc     <= '0;
            y_valid <= 1'b0;
            y_idx   <= '0;
            y_data  <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        relu_q <= act_relu;
                        busy   <= 1'b1;
                        b_addr <= '0;
                        w_base <= '0;
                    end
                end
                BIAS: begin
                    x_addr <= '0;
                    w_addr <= w_base;
                end
                // Read data lags the address by one cycle, so the first MAC cycle
                // consumes the bias and each later one the previous address's product.
                MAC: begin
                    acc <= (x_addr == '0) ? bias_ext : acc_sum;
                    if (x_addr != LAST_I) begin
                        x_addr <= x_addr + XA_W'(1);
                        w_addr <= w_addr + WA_W'(1);
                    end
                end
                DRAIN: begin
                    acc     <= acc_sum;
                    y_data  <= saturate(scale_relu(acc_sum, relu_q));
                    y_idx   <= b_addr;
                    y_valid <= 1'b1;
                end
                OUT: begin
                    if (handshake) begin
                        y_valid <= 1'b0;
                        if (b_addr == LAST_J) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            b_addr <= b_addr + YA_W'(1);
                            w_base <= w_base + WA_W'(N_IN);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed scoreboard bench: two engines (FRAC_SHIFT 0 and 2) share memories
// contents and control, results are popped from per-engine expectation queues.
module tb_dense_layer_engine;

    localparam int NI = 4;
    localparam int NO = 3;
    localparam int W  = 8;

    typedef struct {
        int     idx;
        longint data;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic act_relu = 1'b0;
    logic y_ready = 1'b1;

    logic busy0, done0, yv0, busy1, done1, yv1;
    logic [1:0] xa0, ba0, yi0, xa1, ba1, yi1;
    logic [3:0] wa0, wa1;
    logic signed [W-1:0] xd0, wd0, bd0, yd0, xd1, wd1, bd1, yd1;

    logic signed [W-1:0] xm [NI];
    logic signed [W-1:0] wm [NI*NO];
    logic signed [W-1:0] bm [NO];

    exp_t sb0[$];
    exp_t sb1[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dense_layer_engine #(.N_IN(NI), .N_OUT(NO), .IN_W(W), .B_W(W), .ACC_W(24),
                         .OUT_W(W), .FRAC_SHIFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .start(start), .act_relu(act_relu),
        .busy(busy0), .done(done0),
        .x_addr(xa0), .x_data(xd0), .w_addr(wa0), .w_data(wd0),
        .b_addr(ba0), .b_data(bd0),
        .y_valid(yv0), .y_ready(y_ready), .y_idx(yi0), .y_data(yd0));

    dense_layer_engine #(.N_IN(NI), .N_OUT(NO), .IN_W(W), .B_W(W), .ACC_W(24),
                         .OUT_W(W), .FRAC_SHIFT(2)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .act_relu(act_relu),
        .busy(busy1), .done(done1),
        .x_addr(xa1), .x_data(xd1), .w_addr(wa1), .w_data(wd1),
        .b_addr(ba1), .b_data(bd1),
        .y_valid(yv1), .y_ready(y_ready), .y_idx(yi1), .y_data(yd1));

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        xd0 <= xm[xa0];
        wd0 <= wm[wa0];
        bd0 <= bm[ba0];
        xd1 <= xm[xa1];
        wd1 <= wm[wa1];
        bd1 <= bm[ba1];
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model(input int j, input bit relu, input int fs);
        longint acc;
        acc = longint'(bm[j]);
        for (int i = 0; i < NI; i++) acc += longint'(xm[i]) * longint'(wm[j*NI+i]);
        acc = acc >>> fs;
        if (relu && acc < 0) acc = 0;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    task automatic take(input int d, input logic [1:0] idx, input logic signed [W-1:0] data);
        exp_t e;
        int   sz;
        sz = (d == 0) ? sb0.size() : sb1.size();
        chk($sformatf("d%0d_pending", d), sz != 0, 1);
        if (sz != 0) begin
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk($sformatf("d%0d_idx", d), idx, e.idx);
            chk($sformatf("d%0d_y%0d", d, e.idx), data, e.data);
        end
    endtask

    task automatic run_pass(input bit relu, input bit timing, input bit stall, input bit extra);
        int n, done_at, done1_at, ndone, scnt;
        int vat[3];
        bit stalling;
        logic signed [W-1:0] s_yd;
        logic [1:0] s_yi, s_xa, s_ba;
        logic [3:0] s_wa;
        for (int j = 0; j < NO; j++) begin
            sb0.push_back('{j, model(j, relu, 0)});
            sb1.push_back('{j, model(j, relu, 2)});
        end
        vat = '{0, 0, 0};
        n = 0; done_at = 0; done1_at = 0; ndone = 0; scnt = 0;
        stalling = stall;
        s_yd = '0; s_yi = '0; s_xa = '0; s_ba = '0; s_wa = '0;
        act_relu = relu;
        y_ready = !stall;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 400 && !(done_at != 0 && n >= done_at + 3); k++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                chk("busy_rise", busy0, 1);
            end
            if (n == 2) act_relu = !relu;
            if (extra && n == 3) start = 1'b1;
            if (extra && n == 4) start = 1'b0;
            if (yv0 && yi0 < 2'd3 && vat[yi0] == 0) vat[yi0] = n;
            if (stalling && yv0) begin
                if (scnt == 0) begin
                    s_yd = yd0; s_yi = yi0; s_xa = xa0; s_wa = wa0; s_ba = ba0;
                end else begin
                    chk("stall_valid", yv0, 1);
                    chk("stall_ydata", yd0, s_yd);
                    chk("stall_yidx", yi0, s_yi);
                    chk("stall_xaddr", xa0, s_xa);
                    chk("stall_waddr", wa0, s_wa);
                    chk("stall_baddr", ba0, s_ba);
                end
                scnt++;
                if (scnt == 6) begin
                    y_ready = 1'b1;
                    stalling = 1'b0;
                end
            end
            if (yv0 && y_ready) take(0, yi0, yd0);
            if (yv1 && y_ready) take(1, yi1, yd1);
            if (done0) begin
                ndone++;
                if (done_at == 0) done_at = n;
                if (extra) start = 1'b1;
            end
            if (done1 && done1_at == 0) done1_at = n;
            if (done_at != 0 && n == done_at + 1) start = 1'b0;
            if (done_at != 0 && n == done_at + 2) chk("idle_after_done", busy0, 0);
        end
        start = 1'b0;
        y_ready = 1'b1;
        chk("pass_done", done_at != 0, 1);
        chk("done_count", ndone, 1);
        chk("lat_n0", vat[0], 7);
        if (timing) begin
            chk("lat_n1", vat[1], 14);
            chk("lat_n2", vat[2], 21);
            chk("done_at", done_at, 22);
            chk("d1_done_at", done1_at, 22);
        end
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        sb0.delete();
        sb1.delete();
    endtask

    initial begin
        int cnt;
        xm = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        for (int i = 0; i < NI; i++) begin
            wm[i]        = 8'sd1;
            wm[NI+i]     = -8'sd1;
            wm[2*NI+i]   = 8'sd127;
        end
        bm = '{8'sd5, 8'sd0, 8'sd0};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_valid", yv0, 0);
        chk("rst_yidx", yi0, 0);
        chk("rst_ydata", yd0, 0);
        chk("rst_xaddr", xa0, 0);
        chk("rst_waddr", wa0, 0);
        chk("rst_baddr", ba0, 0);
        rstn = 1'b1;
        @(negedge clk);

        run_pass(1'b0, 1'b1, 1'b0, 1'b0);
        run_pass(1'b1, 1'b1, 1'b0, 1'b1);
        run_pass(1'b0, 1'b0, 1'b1, 1'b0);

        // Abandon a pass while neuron 1 is accumulating.
        act_relu = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", busy0, 1);
        chk("mid_neuron", ba0, 1);
        rstn = 1'b0;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_valid", yv0, 0);
        chk("arst_done", done0, 0);
        chk("arst_ydata", yd0, 0);
        chk("arst_xaddr", xa0, 0);
        chk("arst_waddr", wa0, 0);
        chk("arst_busy1", busy1, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (yv0 || done0 || busy0) cnt++;
        end
        chk("quiet_after_reset", cnt, 0);

        for (int i = 0; i < NI; i++) wm[2*NI+i] = -8'sd128;
        run_pass(1'b0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
